centrifugado_secuenciador: RTL and testbench
============================================

Name: centrifugado_secuenciador

Overview:
- Sequences the spin phase of the washer once a spin time is selected.
- Consumes the one-hot spin-time selection from the spin selector and the 1 Hz tick strobe.
- Runs drain -> ramp-up -> spin -> brake, driving the drain valve, motor speed and status LEDs.
- Sits between the user-selection logic and the motor/valve outputs; reports done and remaining seconds to the display logic.

Parameters:
- DRAIN_S, 10, drain duration in seconds (motor off, valve open)
- RAMP_S, 5, ramp-up duration in seconds (motor low speed)
- BRAKE_S, 8, brake duration in seconds (motor off, valve closed)
- T1_S, 150, spin seconds for selection 4'b0001
- T2_S, 200, spin seconds for selection 4'b0010
- T3_S, 275, spin seconds for selection 4'b0100
- T4_S, 375, spin seconds for selection 4'b1000
- CW, 9, width of the seconds counter; every *_S value must be < 2^CW

Ports:
- clk_in, in, 1, system clock
- iReset, in, 1, synchronous active-high reset
- iTick_1Hz, in, 1, single-cycle strobe once per second, synchronous to clk_in
- iStart, in, 1, start request, level; acted on at its rising edge (registered internally)
- iPausa, in, 1, pause level; while high, counters freeze and motor/valve are off
- iCentri_sel, in, 4, one-hot spin time selection
- iLed_Vaceando, out, 1, drain valve open / drain LED
- iLed_Motor, out, 1, motor enabled
- oMotor_Vel, out, 2, 0 = off, 1 = low, 2 = high; 3 is never driven
- oRemaining, out, CW, seconds left in the current phase
- oFase, out, 3, current state encoding, for display
- oBusy, out, 1, high in any state other than IDLE and FIN
- oDone, out, 1, one-cycle pulse on the transition BRAKE -> FIN
- oError, out, 1, one-cycle pulse when a start is rejected

Behaviour:
- Reset (iReset high at a clk_in edge): state IDLE, all outputs 0, oRemaining 0, start-edge register 0, latched time 0. Reset overrides every other input, including mid-phase.
- States and encodings: IDLE=0, DRAIN=1, RAMP=2, SPIN=3, BRAKE=4, FIN=5.
- Start edge: start_edge = iStart & ~iStart_q.
- IDLE:
  - start_edge with iCentri_sel one-hot: latch the mapped T*_S, go to DRAIN, load oRemaining=DRAIN_S.
  - start_edge with iCentri_sel zero or multi-hot: stay IDLE, pulse oError for 1 cycle.
- Tick countdown: in DRAIN, RAMP, SPIN and BRAKE, each iTick_1Hz with iPausa=0 decrements oRemaining.
- Phase change: on a tick with oRemaining==1, the next cycle shows the next state with the next duration loaded.
  - DRAIN -> RAMP (RAMP_S)
  - RAMP -> SPIN (latched T)
  - SPIN -> BRAKE (BRAKE_S)
  - BRAKE -> FIN (oRemaining=0, oDone=1 for 1 cycle)
- Zero-length phase: if a loaded duration is 0, that phase is skipped in the same cycle; the next phase is loaded instead.
- Outputs per state, registered and updated the cycle after the state change:
  - DRAIN: valve=1, motor=0, vel=0
  - RAMP: valve=1, motor=1, vel=1
  - SPIN: valve=1, motor=1, vel=2
  - BRAKE: valve=0, motor=0, vel=0
  - IDLE/FIN: all 0
- Pause: while iPausa=1 in an active state:
  - forces iLed_Motor=0, oMotor_Vel=0, iLed_Vaceando=0
  - ticks are ignored; state and oRemaining are held
  - on release, state outputs resume the next cycle and counting continues from the held value.
- Selection changes after start are ignored; the time is latched at start.
- start_edge while busy is ignored, with no oError.
- FIN: holds until iStart is low, then returns to IDLE the next cycle. A new start_edge requires iStart low first, so it cannot retrigger in FIN.
- Simultaneous tick and pause: pause wins and there is no decrement.
- Simultaneous tick and reset: reset wins.

Decomposition:
- Package centrifugado_pkg holds:
  - state encodings
  - oMotor_Vel codes (VEL_OFF/LOW/HIGH)
  - function sel_to_time(iCentri_sel) returning the T*_S value and a valid flag
- One sub-module, contador_fase:
  - CW-bit loadable down-counter with load, enable (tick & ~pausa) and a zero-next flag
  - the FSM instantiates it once.

Test Plan:
- Params DRAIN_S=2, RAMP_S=1, BRAKE_S=2, T1_S=3, sel=4'b0001, start pulse, ticks every 4 clocks -> vel sequence 0,1,2,0; phases hold 2,1,3,2 ticks; oDone exactly once after tick 8; FIN until iStart low, then IDLE.
- sel=4'b0011 or 4'b0000 plus start -> oError one cycle, state stays 0, all outputs 0.
- Pause asserted in SPIN at oRemaining=2 for 5 ticks -> motor 0, vel 0, oRemaining stays 2; after release, 2 more ticks reach BRAKE.
- iReset in SPIN with vel=2 -> next cycle all outputs 0, oFase=0; a subsequent start works normally.
- Selection changed 4'b0001 -> 4'b1000 during DRAIN -> SPIN length is still T1_S.
- RAMP_S=0 -> DRAIN goes directly to SPIN; vel never equals 1.

Source files
------------

// File: rtl/centrifugado_pkg.sv
// rtl/centrifugado_pkg.sv - shared types, codes and selection decode for the spin sequencer
package centrifugado_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_RAMP  = 3'd2,
        ST_SPIN  = 3'd3,
        ST_BRAKE = 3'd4,
        ST_FIN   = 3'd5
    } fase_t;

    localparam logic [1:0] VEL_OFF  = 2'd0;
    localparam logic [1:0] VEL_LOW  = 2'd1;
    localparam logic [1:0] VEL_HIGH = 2'd2;

    // Wide enough for any counter width the sequencer is built with
    localparam int TW = 16;

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] t;
    } sel_time_t;

    function automatic sel_time_t sel_to_time(
        input logic [3:0]    sel,
        input logic [TW-1:0] t1,
        input logic [TW-1:0] t2,
        input logic [TW-1:0] t3,
        input logic [TW-1:0] t4
    );
        sel_time_t r;
        r.valid = 1'b1;
        r.t     = '0;
        case (sel)
            4'b0001: r.t = t1;
            4'b0010: r.t = t2;
            4'b0100: r.t = t3;
            4'b1000: r.t = t4;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/centrifugado_secuenciador_contador_fase.sv
// rtl/centrifugado_secuenciador_contador_fase.sv - loadable per-phase seconds down-counter
module contador_fase #(
    parameter int CW = 9
) (
    input  logic          clk_in,
    input  logic          iReset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          zero_next
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Load has priority so a phase change never loses the new duration
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (iReset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign zero_next = en && (count_q == CW'(1));

endmodule

// File: rtl/centrifugado_secuenciador.sv
// rtl/centrifugado_secuenciador.sv - drain/ramp/spin/brake sequencer for the washer spin cycle
module centrifugado_secuenciador
    import centrifugado_pkg::*;
#(
    parameter int DRAIN_S = 10,
    parameter int RAMP_S  = 5,
    parameter int BRAKE_S = 8,
    parameter int T1_S    = 150,
    parameter int T2_S    = 200,
    parameter int T3_S    = 275,
    parameter int T4_S    = 375,
    parameter int CW      = 9
) (
    input  logic          clk_in,
    input  logic          iReset,
    input  logic          iTick_1Hz,
    input  logic          iStart,
    input  logic          iPausa,
    input  logic [3:0]    iCentri_sel,
    output logic          iLed_Vaceando,
    output logic          iLed_Motor,
    output logic [1:0]    oMotor_Vel,
    output logic [CW-1:0] oRemaining,
    output logic [2:0]    oFase,
    output logic          oBusy,
    output logic          oDone,
    output logic          oError
);

    fase_t         state_q, state_d;
    logic [CW-1:0] time_q, time_d;
    logic          start_q, start_d;
    logic          valve_q, valve_d;
    logic          motor_q, motor_d;
    logic [1:0]    vel_q, vel_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          start_edge;
    logic          active;
    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_zero_next;
    logic [CW-1:0] cnt_value;
    sel_time_t     sel_time;
    logic [CW-1:0] sel_t;
    logic          unused_sel_hi;

    assign sel_time      = sel_to_time(iCentri_sel, TW'(T1_S), TW'(T2_S), TW'(T3_S), TW'(T4_S));
    assign sel_t         = sel_time.t[CW-1:0];
    assign unused_sel_hi = ^sel_time.t[TW-1:CW];

    assign start_edge = iStart & ~start_q;
    assign active     = (state_q == ST_DRAIN) || (state_q == ST_RAMP) ||
                        (state_q == ST_SPIN)  || (state_q == ST_BRAKE);

    function automatic logic [CW-1:0] dur_of(input fase_t f, input logic [CW-1:0] t_spin);
        case (f)
            ST_DRAIN: return CW'(DRAIN_S);
            ST_RAMP:  return CW'(RAMP_S);
            ST_SPIN:  return t_spin;
            ST_BRAKE: return CW'(BRAKE_S);
            default:  return '0;
        endcase
    endfunction

    // First phase at or after 'from' with a nonzero duration; zero-length phases collapse into one cycle
    function automatic fase_t first_phase(input fase_t from, input logic [CW-1:0] t_spin);
        fase_t r;
        r = ST_FIN;
        for (int i = 4; i >= 1; i--) begin
            if ((i >= int'(from)) && (dur_of(fase_t'(3'(i)), t_spin) != '0)) begin
                r = fase_t'(3'(i));
            end
        end
        return r;
    endfunction

    contador_fase #(.CW(CW)) u_contador (
        .clk_in    (clk_in),
        .iReset    (iReset),
        .load      (cnt_load),
        .load_val  (cnt_load_val),
        .en        (iTick_1Hz & ~iPausa & active),
        .count     (cnt_value),
        .zero_next (cnt_zero_next)
    );

    always_ff @(posedge clk_in) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            start_q <= 1'b0;
            valve_q <= 1'b0;
            motor_q <= 1'b0;
            vel_q   <= VEL_OFF;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            start_q <= start_d;
            valve_q <= valve_d;
            motor_q <= motor_d;
            vel_q   <= vel_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        time_d       = time_q;
        start_d      = iStart;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge && sel_time.valid) begin
                    time_d       = sel_t;
                    state_d      = first_phase(ST_DRAIN, sel_t);
                    cnt_load     = 1'b1;
                    cnt_load_val = dur_of(state_d, sel_t);
                end
            end
            ST_DRAIN, ST_RAMP, ST_SPIN, ST_BRAKE: begin
                if (cnt_zero_next) begin
                    state_d      = first_phase(fase_t'(state_q + 3'd1), time_q);
                    cnt_load     = 1'b1;
                    cnt_load_val = dur_of(state_d, time_q);
                end
            end
            ST_FIN: begin
                if (!iStart) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valve_d = 1'b0;
        motor_d = 1'b0;
        vel_d   = VEL_OFF;
        if (!iPausa) begin
            case (state_q)
                ST_DRAIN: valve_d = 1'b1;
                ST_RAMP: begin
                    valve_d = 1'b1;
                    motor_d = 1'b1;
                    vel_d   = VEL_LOW;
                end
                ST_SPIN: begin
                    valve_d = 1'b1;
                    motor_d = 1'b1;
                    vel_d   = VEL_HIGH;
                end
                default: ;
            endcase
        end
        done_d  = (state_q != ST_FIN) && (state_d == ST_FIN);
        error_d = (state_q == ST_IDLE) && start_edge && !sel_time.valid;
    end

    assign iLed_Vaceando = valve_q;
    assign iLed_Motor    = motor_q;
    assign oMotor_Vel    = vel_q;
    assign oRemaining    = cnt_value;
    assign oFase         = state_q;
    assign oBusy         = active;
    assign oDone         = done_q;
    assign oError        = error_q;

endmodule

// File: tb/tb_centrifugado_secuenciador.sv
// tb/tb_centrifugado_secuenciador.sv - randomized self-checking bench for the spin sequencer
module tb_centrifugado_secuenciador;

    localparam int CW = 9;
    localparam int DRAIN = 2;
    localparam int RAMP = 1;
    localparam int BRAKE = 2;
    localparam int TV [4] = '{3, 4, 5, 6};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, tick, start, pausa;
    logic [3:0]    sel;
    logic          valve_a, motor_a, busy_a, done_a, err_a;
    logic [1:0]    vel_a;
    logic [CW-1:0] rem_a;
    logic [2:0]    fase_a;
    logic          valve_b, motor_b, busy_b, done_b, err_b;
    logic [1:0]    vel_b;
    logic [CW-1:0] rem_b;
    logic [2:0]    fase_b;

    centrifugado_secuenciador #(
        .DRAIN_S(DRAIN), .RAMP_S(RAMP), .BRAKE_S(BRAKE),
        .T1_S(3), .T2_S(4), .T3_S(5), .T4_S(6), .CW(CW)
    ) dut (
        .clk_in(clk), .iReset(rst), .iTick_1Hz(tick), .iStart(start), .iPausa(pausa),
        .iCentri_sel(sel), .iLed_Vaceando(valve_a), .iLed_Motor(motor_a), .oMotor_Vel(vel_a),
        .oRemaining(rem_a), .oFase(fase_a), .oBusy(busy_a), .oDone(done_a), .oError(err_a)
    );

    centrifugado_secuenciador #(
        .DRAIN_S(DRAIN), .RAMP_S(0), .BRAKE_S(BRAKE),
        .T1_S(3), .T2_S(4), .T3_S(5), .T4_S(6), .CW(CW)
    ) dut_z (
        .clk_in(clk), .iReset(rst), .iTick_1Hz(tick), .iStart(start), .iPausa(pausa),
        .iCentri_sel(sel), .iLed_Vaceando(valve_b), .iLed_Motor(motor_b), .oMotor_Vel(vel_b),
        .oRemaining(rem_b), .oFase(fase_b), .oBusy(busy_b), .oDone(done_b), .oError(err_b)
    );

    int n_vec = 0;
    int n_bad = 0;
    int done_a_cnt = 0;
    int done_b_cnt = 0;
    int vel1_b_cnt = 0;

    always @(negedge clk) begin
        if (done_a) done_a_cnt++;
        if (done_b) done_b_cnt++;
        if (vel_b == 2'd1) vel1_b_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Phase and seconds left after e counted ticks, from the phase durations alone
    function automatic void model(input int e, input int d0, input int d1, input int d2,
                                  input int d3, output int ph, output int rem);
        int d [4];
        int cum;
        d = '{d0, d1, d2, d3};
        cum = 0;
        ph = 5;
        rem = 0;
        for (int i = 0; i < 4; i++) begin
            if (e < cum + d[i]) begin
                ph = i + 1;
                rem = cum + d[i] - e;
                return;
            end
            cum += d[i];
        end
    endfunction

    function automatic int exp_vel(input int ph, input bit p);
        if (p) return 0;
        return (ph == 2) ? 1 : (ph == 3) ? 2 : 0;
    endfunction

    function automatic int exp_valve(input int ph, input bit p);
        return (!p && ph >= 1 && ph <= 3) ? 1 : 0;
    endfunction

    function automatic int exp_motor(input int ph, input bit p);
        return (!p && (ph == 2 || ph == 3)) ? 1 : 0;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int e, input int t, input bit p);
        int ph, rem;
        model(e, DRAIN, RAMP, t, BRAKE, ph, rem);
        chk({tag, ".fase"}, fase_a, ph);
        chk({tag, ".rem"}, rem_a, rem);
        chk({tag, ".vel"}, vel_a, exp_vel(ph, p));
        chk({tag, ".motor"}, motor_a, exp_motor(ph, p));
        chk({tag, ".valve"}, valve_a, exp_valve(ph, p));
        chk({tag, ".busy"}, busy_a, (ph >= 1 && ph <= 4) ? 1 : 0);
        model(e, DRAIN, 0, t, BRAKE, ph, rem);
        chk({tag, ".z.fase"}, fase_b, ph);
        chk({tag, ".z.rem"}, rem_b, rem);
        chk({tag, ".z.vel"}, vel_b, exp_vel(ph, p));
    endtask

    task automatic do_tick(input bit p, input int t, inout int e);
        pausa = p;
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(3);
        if (!p) e++;
        check_all("tick", e, t, p);
    endtask

    task automatic start_run(input int k, output int t);
        sel = 4'b0001 << k;
        t = TV[k];
        start = 1'b1;
        cyc(3);
        check_all("start", 0, t, 1'b0);
    endtask

    task automatic finish_run(input int t, input int e, input int da0, input int db0);
        int total;
        total = DRAIN + RAMP + t + BRAKE;
        chk("ticks_in_budget", e, total);
        pausa = 1'b0;
        cyc(1);
        chk("fin.fase", fase_a, 5);
        chk("fin.rem", rem_a, 0);
        chk("fin.busy", busy_a, 0);
        chk("fin.done_once", done_a_cnt - da0, 1);
        chk("fin.z.done_once", done_b_cnt - db0, 1);
        cyc(3);
        chk("fin.hold", fase_a, 5);
        start = 1'b0;
        cyc(2);
        chk("fin.to_idle", fase_a, 0);
        chk("fin.z.to_idle", fase_b, 0);
    endtask

    task automatic random_run(input int k);
        int t, e, total, da0, db0;
        da0 = done_a_cnt;
        db0 = done_b_cnt;
        e = 0;
        start_run(k, t);
        total = DRAIN + RAMP + t + BRAKE;
        for (int n = 0; n < 80 && e < total; n++) begin
            if ($urandom_range(0, 4) == 0) sel = 4'($urandom);
            do_tick($urandom_range(0, 3) == 0, t, e);
        end
        finish_run(t, e, da0, db0);
    endtask

    logic [3:0] bad_sel [3];

    initial begin
        int t, e, da0, db0;
        rst = 1'b1; tick = 1'b0; start = 1'b0; pausa = 1'b0; sel = 4'b0000;
        cyc(2);
        chk("rst.fase", fase_a, 0);
        chk("rst.rem", rem_a, 0);
        chk("rst.vel", vel_a, 0);
        chk("rst.outs", {valve_a, motor_a, busy_a, done_a, err_a}, 0);
        rst = 1'b0;
        cyc(1);

        bad_sel = '{4'b0000, 4'b0011, 4'b1110};
        for (int i = 0; i < 3; i++) begin
            sel = bad_sel[i];
            start = 1'b1;
            cyc(1);
            chk("err.pulse", err_a, 1);
            chk("err.fase", fase_a, 0);
            cyc(1);
            chk("err.one_cycle", err_a, 0);
            chk("err.stay_idle", {fase_a, valve_a, motor_a, vel_a, rem_a}, 0);
            start = 1'b0;
            cyc(1);
        end

        // Pause held in SPIN with two seconds left, selection changed mid-run
        da0 = done_a_cnt; db0 = done_b_cnt; e = 0;
        start_run(0, t);
        do_tick(1'b0, t, e);
        sel = 4'b1000;
        repeat (3) do_tick(1'b0, t, e);
        chk("pause.pre_rem", rem_a, 2);
        repeat (5) do_tick(1'b1, t, e);
        chk("pause.held_rem", rem_a, 2);
        chk("pause.held_fase", fase_a, 3);
        repeat (2) do_tick(1'b0, t, e);
        chk("pause.brake", fase_a, 4);
        repeat (2) do_tick(1'b0, t, e);
        finish_run(t, e, da0, db0);

        // Reset mid-SPIN
        e = 0;
        start_run(0, t);
        repeat (4) do_tick(1'b0, t, e);
        chk("rst_spin.vel_before", vel_a, 2);
        rst = 1'b1;
        start = 1'b0;
        cyc(1);
        chk("rst_spin.fase", fase_a, 0);
        chk("rst_spin.outs", {valve_a, motor_a, vel_a, rem_a, busy_a}, 0);
        rst = 1'b0;
        cyc(1);
        random_run(3);

        for (int r = 0; r < 8; r++) random_run($urandom_range(0, 3));

        chk("z.vel_never_low", vel1_b_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
